// File: rtl/my_chip_fpu16_if.sv
// Pad-level bus of the nibble-serial half-precision unit: 12 input pads and 12 output pads.
interface my_chip_fpu16_if;
   logic [11:0] io_in;
   logic [11:0] io_out;

   modport master (output io_in, input io_out);
   modport slave  (input io_in, output io_out);
endinterface

// File: rtl/my_chip_fpu16.sv
// Nibble-serial binary16 add/multiply unit: 4-cycle operand load, 3-cycle calc,
// result returned as two bytes under a valid flag. Truncating rounding throughout.
module my_chip_fpu16 (
   input  logic            clock,
   input  logic            reset,
   my_chip_fpu16_if.slave  io
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_OUT_LO, S_OUT_HI} state_t;

   state_t      r_state;
   logic [1:0]  r_cnt;
   logic        r_op;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [15:0] r_result;
   logic [8:0]  r_out;

   logic [21:0] w_prod;
   logic [15:0] w_result;
   logic        w_unused;

   function automatic logic [3:0] f_lz(input logic [13:0] v);
      logic [3:0] lz;
      lz = 4'd14;
      for (int i = 0; i < 14; i++)
         if (v[i]) lz = 4'(13 - i);
      return lz;
   endfunction

   function automatic logic [15:0] f_add(input logic [15:0] a, input logic [15:0] b);
      logic        a_nan, b_nan, a_inf, b_inf, eff_sub;
      logic [15:0] big, sml;
      logic [5:0]  e_big, e_sml, diff, shamt, lim, sh, e_res;
      logic [13:0] x_big, x_sml, shifted;
      logic [27:0] wide;
      logic [14:0] sum;
      logic [10:0] norm;
      a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
      b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
      a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
      b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
      if (a_nan) return a;
      if (b_nan) return b;
      if (a_inf && b_inf && (a[15] != b[15])) return 16'h7E00;
      if (a_inf) return a;
      if (b_inf) return b;
      if (a[14:0] >= b[14:0]) begin
         big = a; sml = b;
      end else begin
         big = b; sml = a;
      end
      // Subnormals use effective exponent 1 and hidden bit 0
      e_big = (big[14:10] == 5'd0) ? 6'd1 : {1'b0, big[14:10]};
      e_sml = (sml[14:10] == 5'd0) ? 6'd1 : {1'b0, sml[14:10]};
      x_big = {big[14:10] != 5'd0, big[9:0], 3'b000};
      x_sml = {sml[14:10] != 5'd0, sml[9:0], 3'b000};
      diff  = e_big - e_sml;
      shamt = (diff > 6'd14) ? 6'd14 : diff;
      wide  = {x_sml, 14'd0} >> shamt;
      x_sml = wide[27:14] | {13'd0, |wide[13:0]};
      eff_sub = big[15] ^ sml[15];
      sum = eff_sub ? ({1'b0, x_big} - {1'b0, x_sml}) : ({1'b0, x_big} + {1'b0, x_sml});
      if (sum == 15'd0) return {~eff_sub & big[15], 15'd0};
      if (sum[14]) begin
         norm  = sum[14:4];
         e_res = e_big + 6'd1;
      end else begin
         // Left-normalize, but stop at exponent 1 so tiny results stay subnormal
         lim     = e_big - 6'd1;
         sh      = ({2'b00, f_lz(sum[13:0])} > lim) ? lim : {2'b00, f_lz(sum[13:0])};
         shifted = sum[13:0] << sh;
         norm    = 11'(shifted >> 3);
         e_res   = e_big - sh;
      end
      if (e_res >= 6'd31) return {big[15], 5'h1F, 10'd0};
      return {big[15], norm[10] ? e_res[4:0] : 5'd0, norm[9:0]};
   endfunction

   function automatic logic [15:0] f_mul(input logic [15:0] a, input logic [15:0] b,
                                         input logic [11:0] prod_hi);
      logic       a_nan, b_nan, a_inf, b_inf, sgn;
      logic [6:0] esum, e_res;
      logic [9:0] frac;
      a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
      b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
      a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
      b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
      sgn   = a[15] ^ b[15];
      if (a_nan) return a;
      if (b_nan) return b;
      if ((a_inf && b[14:10] == 5'd0) || (b_inf && a[14:10] == 5'd0)) return 16'h7E00;
      if (a_inf || b_inf) return {sgn, 5'h1F, 10'd0};
      if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {sgn, 15'd0};
      esum = 7'(a[14:10]) + 7'(b[14:10]) + 7'(prod_hi[11]);
      if (esum < 7'd16) return {sgn, 15'd0};
      e_res = esum - 7'd15;
      if (e_res >= 7'd31) return {sgn, 5'h1F, 10'd0};
      frac = prod_hi[11] ? prod_hi[10:1] : prod_hi[9:0];
      return {sgn, e_res[4:0], frac};
   endfunction

   assign w_prod = 22'({1'b1, r_a[9:0]}) * 22'({1'b1, r_b[9:0]});

   always_comb begin
      w_result = r_op ? f_add(r_a, r_b) : f_mul(r_a, r_b, w_prod[21:10]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= 2'd0;
         r_op     <= 1'b0;
         r_a      <= 16'd0;
         r_b      <= 16'd0;
         r_result <= 16'd0;
         r_out    <= 9'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_out <= 9'd0;
               if (io.io_in[9]) begin
                  r_op    <= io.io_in[8];
                  r_cnt   <= 2'd0;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               // Least-significant nibble arrives first, so shift in from the top
               r_a   <= {io.io_in[3:0], r_a[15:4]};
               r_b   <= {io.io_in[7:4], r_b[15:4]};
               r_cnt <= r_cnt + 2'd1;
               if (r_cnt == 2'd3) begin
                  r_cnt   <= 2'd0;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_result <= w_result;
               r_cnt    <= r_cnt + 2'd1;
               if (r_cnt == 2'd2) begin
                  r_cnt   <= 2'd0;
                  r_out   <= {1'b1, r_result[7:0]};
                  r_state <= S_OUT_LO;
               end
            end
            S_OUT_LO: begin
               r_out   <= {1'b1, r_result[15:8]};
               r_state <= S_OUT_HI;
            end
            S_OUT_HI: begin
               r_out   <= 9'd0;
               r_state <= S_IDLE;
            end
            default: begin
               r_out   <= 9'd0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign io.io_out = {3'b000, r_out};
   assign w_unused  = &{1'b0, io.io_in[11:10], w_prod[9:0]};

endmodule

// File: tb/tb_my_chip_fpu16.sv
// Bench for the nibble-serial binary16 unit: vector table driven serially,
// results checked by a negedge monitor against a scoreboard queue.
module tb_my_chip_fpu16;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        op;
      logic [15:0] want;
   } vec_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   valid_cycles;
   int   n_pushed;
   int   mon_state;
   logic [7:0]  mon_lo;
   logic [15:0] sb_exp[$];
   int          sb_c0[$];
   int          sb_idx[$];
   vec_t        vecs[23];

   my_chip_fpu16_if io ();

   my_chip_fpu16 dut (
      .clock (clk),
      .reset (rst),
      .io    (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Drives one transaction; enable and op bit are randomised after E0 since the DUT must ignore them
   task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic op,
                          input logic [15:0] want, input int idx);
      @(negedge clk);
      io.io_in = {2'b00, 1'b1, op, 8'($urandom)};
      @(posedge clk);
      @(negedge clk);
      sb_exp.push_back(want);
      sb_c0.push_back(cyc);
      sb_idx.push_back(idx);
      n_pushed++;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         io.io_in = {2'($urandom), 1'($urandom), 1'($urandom), b[4*k +: 4], a[4*k +: 4]};
         @(posedge clk);
      end
      io.io_in[9] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      io.io_in = 12'd0;
      repeat (3) @(posedge clk);
   endtask

   initial begin : monitor
      mon_state = 0;
      mon_lo    = 8'd0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (io.io_out[8]) valid_cycles++;
            if (mon_state == 0) begin
               if (sb_exp.size() == 0) begin
                  check("idle_no_valid", {31'd0, io.io_out[8]}, 32'd0);
               end else if (io.io_out[8]) begin
                  check($sformatf("lo_latency[%0d]", sb_idx[0]), cyc, sb_c0[0] + 7);
                  mon_lo    = io.io_out[7:0];
                  mon_state = 1;
               end
            end else begin
               check($sformatf("hi_valid[%0d]", sb_idx[0]), {31'd0, io.io_out[8]}, 32'd1);
               check($sformatf("tie0[%0d]", sb_idx[0]), {29'd0, io.io_out[11:9]}, 32'd0);
               check($sformatf("result[%0d]", sb_idx[0]), {16'd0, io.io_out[7:0], mon_lo},
                     {16'd0, sb_exp[0]});
               void'(sb_exp.pop_front());
               void'(sb_c0.pop_front());
               void'(sb_idx.pop_front());
               mon_state = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      n_checks = 0; n_fail = 0; valid_cycles = 0; n_pushed = 0; cyc = 0;
      vecs[0]  = '{16'h5051, 16'h5051, 1'b1, 16'h5451};
      vecs[1]  = '{16'h5007, 16'h5007, 1'b0, 16'h640E};
      vecs[2]  = '{16'h5051, 16'hD051, 1'b1, 16'h0000};
      vecs[3]  = '{16'h5007, 16'hD007, 1'b0, 16'hE40E};
      vecs[4]  = '{16'h4D86, 16'hC91C, 1'b1, 16'h49F0};
      vecs[5]  = '{16'hCD86, 16'h491C, 1'b1, 16'hC9F0};
      vecs[6]  = '{16'hC976, 16'hC26C, 1'b0, 16'h5062};
      vecs[7]  = '{16'h4D3D, 16'h48EA, 1'b1, 16'h4FB2};
      vecs[8]  = '{16'hCD3D, 16'hC8EA, 1'b1, 16'hCFB2};
      vecs[9]  = '{16'h4976, 16'h426C, 1'b0, 16'h5062};
      vecs[10] = '{16'h426C, 16'hC976, 1'b0, 16'hD062};
      vecs[11] = '{16'h03FF, 16'h0001, 1'b1, 16'h0400};
      vecs[12] = '{16'h03FF, 16'h03FF, 1'b1, 16'h07FE};
      vecs[13] = '{16'h03FF, 16'h0001, 1'b0, 16'h0000};
      vecs[14] = '{16'h03FF, 16'h03FF, 1'b0, 16'h0000};
      vecs[15] = '{16'h7BFF, 16'h7BFF, 1'b1, 16'h7C00};
      vecs[16] = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00};
      vecs[17] = '{16'h7C00, 16'h3666, 1'b1, 16'h7C00};
      vecs[18] = '{16'h7C00, 16'h3666, 1'b0, 16'h7C00};
      vecs[19] = '{16'hFC00, 16'h0015, 1'b1, 16'hFC00};
      vecs[20] = '{16'hFFFF, 16'h7BFF, 1'b0, 16'hFFFF};
      vecs[21] = '{16'hFFFF, 16'h7BFF, 1'b1, 16'hFFFF};
      vecs[22] = '{16'h7C00, 16'hFC00, 1'b1, 16'h7E00};

      rst = 1'b1;
      io.io_in = 12'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_io_out", {20'd0, io.io_out}, 32'd0);
      rst = 1'b0;

      // Back-to-back: each call asserts enable on the edge right after the previous E9
      for (int i = 0; i < 23; i++)
         run_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].want, i);

      // Abort during nibble 2: no valid pulse may follow
      @(negedge clk);
      io.io_in = {2'b00, 1'b1, 1'b1, 8'h00};
      @(posedge clk);
      @(negedge clk);
      io.io_in = {2'b00, 1'b0, 1'b0, 4'h1, 4'h1};
      @(posedge clk);
      @(negedge clk);
      io.io_in = {2'b00, 1'b0, 1'b0, 4'h5, 4'h5};
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      io.io_in = {2'b00, 1'b0, 1'b0, 4'h0, 4'h0};
      @(posedge clk);
      @(negedge clk);
      check("abort_io_out", {20'd0, io.io_out}, 32'd0);
      rst = 1'b0;
      io.io_in = 12'd0;
      repeat (12) @(posedge clk);

      run_txn(16'h5051, 16'h5051, 1'b1, 16'h5451, 100);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", sb_exp.size(), 32'd0);
      check("valid_cycle_count", valid_cycles, 2 * n_pushed);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
